// File: rtl/word_byte_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
//
// Feeds the 4:1 byte-select mux stage. A 32-bit word is taken over a
// valid/ready handshake and its four bytes are held on registered lane
// outputs. The 2-bit select then steps through the valid bytes, one per
// accepted output beat, so the mux output streams bytes downstream.
// A short final word (1..3 valid bytes), an end-of-message marker and a
// running byte count are supported.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream word handshake
//   in_word             word, byte k at in_word[8k+7:8k]
//   in_nbytes           valid bytes in in_word (1..4; 0 or >4 means 4)
//   in_last             word is the final word of the message
//   lane0..lane3        registered bytes 0..3 to mux inputs a0..a3
//   sel                 registered mux select (index of presented byte)
//   out_valid/out_ready downstream byte handshake
//   out_last            presented byte is the final byte of the message
//   byte_count          beats since reset or since the last out_last beat
// -----------------------------------------------------------------------------
module word_byte_serializer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    input  logic [2:0]       in_nbytes,
    input  logic             in_last,
    output logic [7:0]       lane0,
    output logic [7:0]       lane1,
    output logic [7:0]       lane2,
    output logic [7:0]       lane3,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [1:0] cnt;        // index of the last valid byte of the held word
    logic       last_flag;  // held word closes the message
    logic [1:0] load_cnt;   // last-byte index derived from in_nbytes
    logic       beat;
    logic       final_beat;
    logic       load;

    // Out-of-range byte counts (0, 5..7) fall back to a full word.
    always_comb begin
        case (in_nbytes)
            3'd1:    load_cnt = 2'd0;
            3'd2:    load_cnt = 2'd1;
            3'd3:    load_cnt = 2'd2;
            default: load_cnt = 2'd3;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no path through
    // the case leaves it unassigned and turns it into a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        beat       = 1'b0;
        final_beat = 1'b0;
        case (state)
            IDLE: begin
                // rst_n gates in_ready so it reads 0 for the whole reset
                // window, not just once the flops have cleared.
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                out_valid  = 1'b1;
                out_last   = last_flag && (sel == cnt);
                beat       = out_ready;
                final_beat = out_ready && (sel == cnt);
                // Accepting in the final-byte cycle gives back-to-back words
                // with no idle cycle between them.
                if (final_beat) begin
                    in_ready = rst_n;
                    if (!in_valid) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the lanes are a handful of flops on the output path, not a RAM,
    // so they are reset with everything else; that keeps the mux inputs at a
    // known zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane0      <= '0;
            lane1      <= '0;
            lane2      <= '0;
            lane3      <= '0;
            sel        <= '0;
            cnt        <= '0;
            last_flag  <= 1'b0;
            byte_count <= '0;
        end else begin
            if (load) begin
                lane0     <= in_word[7:0];
                lane1     <= in_word[15:8];
                lane2     <= in_word[23:16];
                lane3     <= in_word[31:24];
                sel       <= 2'd0;
                cnt       <= load_cnt;
                last_flag <= in_last;
            end else if (beat) begin
                sel <= final_beat ? 2'd0 : sel + 2'd1;
            end

            // Clearing on the message's last byte makes the next message's
            // first byte read 0.
            if (beat) begin
                byte_count <= out_last ? '0 : byte_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_byte_serializer
//
// Scoreboard bench. Each accepted word is expanded into its expected byte
// beats (data, select index, last marker) and queued; a monitor on the
// falling edge compares every presented byte against the queue head and
// tracks the expected byte count arithmetically. Directed phases follow the
// block's key scenarios, then randomized words with random backpressure.
// -----------------------------------------------------------------------------
module tb_word_byte_serializer;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_word;
    logic [2:0]       in_nbytes;
    logic             in_last;
    logic [7:0]       lane0, lane1, lane2, lane3;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [CNT_W-1:0] byte_count;

    word_byte_serializer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .in_nbytes  (in_nbytes),
        .in_last    (in_last),
        .lane0      (lane0),
        .lane1      (lane1),
        .lane2      (lane2),
        .lane3      (lane3),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         idx;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    exp_cnt    = 0;
    int    beat_total = 0;
    int    n_checks   = 0;
    int    n_fail     = 0;

    int    rdy_mode   = 0;   // 0: always ready, 1: random, 2: one 3-cycle stall at sel 1
    int    stall_left = 0;
    bit    stall_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mux_out();
        case (sel)
            2'd0:    return lane0;
            2'd1:    return lane1;
            2'd2:    return lane2;
            default: return lane3;
        endcase
    endfunction

    // Monitor / scoreboard: falling edge, inputs and outputs are settled.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_cnt = 0;
                check("in_ready_in_reset", in_ready, 0);
                check("out_valid_in_reset", out_valid, 0);
            end else begin
                check("out_valid", out_valid, exp_q.size() != 0);
                check("in_ready", in_ready,
                      (exp_q.size() == 0) || (out_ready && exp_q.size() == 1));
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("byte_data", mux_out(), e.data);
                    check("sel", sel, e.idx);
                    check("out_last", out_last, e.last);
                    check("byte_count", byte_count, exp_cnt);
                    exp_cnt = e.last ? 0 : (exp_cnt + 1) % CNT_MOD;
                    beat_total++;
                end
                if (in_valid && in_ready) begin
                    int nb;
                    nb = (in_nbytes == 0 || in_nbytes > 4) ? 4 : int'(in_nbytes);
                    for (int k = 0; k < nb; k++) begin
                        exp_q.push_back('{in_word[8*k +: 8], k, in_last && (k == nb - 1)});
                    end
                end
            end
        end
    end

    // Downstream ready generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else if (!stall_done && out_valid && sel == 2'd1) begin
                        out_ready  = 1'b0;
                        stall_left = 2;
                        stall_done = 1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send_word(input logic [31:0] w, input logic [2:0] nb, input logic last);
        bit ok;
        ok        = 0;
        in_valid  = 1'b1;
        in_word   = w;
        in_nbytes = nb;
        in_last   = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_in_time", ok, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        check("drained", exp_q.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int start;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        in_nbytes = '0;
        in_last   = 1'b0;

        // Reset state.
        #3;
        check("rst_lane0", lane0, 0);
        check("rst_lane3", lane3, 0);
        check("rst_sel", sel, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_in_ready", in_ready, 0);
        #20;
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single full word closing a message.
        send_word(32'h4433_2211, 3'd4, 1'b1);
        drain();

        // Back-to-back words with in_valid held high.
        send_word(32'hDDCC_BBAA, 3'd4, 1'b0);
        send_word(32'h0403_0201, 3'd4, 1'b1);
        drain();

        // Short final word, then an nbytes=0 word treated as four bytes.
        send_word(32'h0000_BEEF, 3'd2, 1'b1);
        drain();
        send_word(32'hA1B2_C3D4, 3'd0, 1'b1);
        drain();

        // Backpressure: three-cycle stall while byte 1 is presented.
        rdy_mode   = 2;
        stall_done = 0;
        send_word(32'h8765_4321, 3'd4, 1'b1);
        drain();
        check("stall_happened", stall_done, 1);
        rdy_mode = 0;

        // Counter wrap: 20 bytes without last, then a closing byte.
        for (int i = 0; i < 5; i++) begin
            send_word($urandom, 3'd4, 1'b0);
        end
        drain();
        check("wrap_count", byte_count, 20 % CNT_MOD);
        send_word(32'h0000_0055, 3'd1, 1'b1);
        drain();

        // Reset during a word, right after its 2nd beat.
        start = beat_total;
        send_word(32'hCAFE_F00D, 3'd4, 1'b1);
        for (int i = 0; i < 50 && beat_total < start + 2; i++) begin
            @(negedge clk);
        end
        check("two_beats_before_reset", beat_total - start, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_lane0", lane0, 0);
        check("mid_rst_lane1", lane1, 0);
        check("mid_rst_lane2", lane2, 0);
        check("mid_rst_lane3", lane3, 0);
        check("mid_rst_sel", sel, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_byte_count", byte_count, 0);
        check("mid_rst_in_ready", in_ready, 0);
        idle_cycles(2);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        idle_cycles(5);
        send_word(32'h1357_9BDF, 3'd3, 1'b1);
        drain();

        // Randomized words, sizes, gaps and backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            send_word($urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                idle_cycles($urandom_range(1, 3));
            end
        end
        rdy_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
